// File: rtl/pdl_if.sv
// Trigger/program/pulse bundle for the pdl delay line; master drives trigger and timing, slave returns delay_out.
interface pdl_if #(
  parameter int WIDTH = 32
);
  logic             trigger;
  logic [WIDTH-1:0] wb;
  logic [WIDTH-1:0] dl;
  logic             delay_out;

  modport master (output trigger, output wb, output dl, input delay_out);
  modport slave  (input trigger, input wb, input dl, output delay_out);
endinterface

// File: rtl/pdl.sv
// Programmable pulse delay line: rising trigger edge -> wait dl cycles -> wb-cycle pulse on delay_out.
// Define PDL_RETRIGGER_EN to let edges during DELAY/PULSE restart the sequence.
module pdl #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  pdl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

  state_t           state_q, state_d, start_state;
  logic [WIDTH-1:0] dcnt_q, dcnt_d;
  logic [WIDTH-1:0] wcnt_q, wcnt_d;
  logic             trig_q;
  logic             out_q;
  logic             rise;
  logic             accept;

  assign rise = bus.trigger & ~trig_q;

`ifdef PDL_RETRIGGER_EN
  assign accept = rise;
`else
  assign accept = rise && (state_q == IDLE);
`endif

  // A zero delay goes straight to the pulse; zero width produces nothing at all.
  always_comb begin
    start_state = IDLE;
    if (bus.dl != '0) begin
      start_state = DELAY;
    end else if (bus.wb != '0) begin
      start_state = PULSE;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      DELAY: begin
        dcnt_d = dcnt_q - WIDTH'(1);
        if (dcnt_d == '0) begin
          state_d = (wcnt_q != '0) ? PULSE : IDLE;
        end
      end
      PULSE: begin
        wcnt_d = wcnt_q - WIDTH'(1);
        if (wcnt_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = state_q;
    endcase
    if (accept) begin
      state_d = start_state;
      dcnt_d  = bus.dl;
      wcnt_d  = bus.wb;
    end
  end

  // trig_q resets high so a trigger held across reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      wcnt_q  <= '0;
      trig_q  <= 1'b1;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      wcnt_q  <= wcnt_d;
      trig_q  <= bus.trigger;
      out_q   <= (state_q == PULSE);
    end
  end

  assign bus.delay_out = out_q;
endmodule

// File: tb/tb_pdl.sv
// Directed bench for pdl: absolute-time trigger vectors with hand-computed pulse edges and widths.
module tb_pdl;
  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   hi_cnt = 0;
  int   hi0;
  time  rise_t = 0;
  time  fall_t = 0;

  pdl_if #(.WIDTH(32)) bus_if ();

  pdl #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge bus_if.delay_out) rise_t = $time;
  always @(negedge bus_if.delay_out) fall_t = $time;
  always @(negedge clk) if (bus_if.delay_out === 1'b1) hi_cnt++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_until(input time t);
    if ($time < t) #(t - $time);
  endtask

  initial begin
    reset          = 1'b1;
    bus_if.trigger = 1'b0;
    bus_if.wb      = 32'd1;
    bus_if.dl      = 32'd1;
    #12;
    check("reset_out", bus_if.delay_out, 0);
    wait_until(20);
    reset = 1'b0;

    // dl=1 wb=1, edge detected at 405
    wait_until(400);
    hi0 = hi_cnt;
    bus_if.trigger = 1'b1;
    wait_until(460);
    bus_if.trigger = 1'b0;
    wait_until(500);
    check("t1_rise", rise_t, 425);
    check("t1_fall", fall_t, 435);
    check("t1_width", hi_cnt - hi0, 1);

    // dl=2 wb=2, edges at 805/1005/1205
    bus_if.wb = 32'd2;
    bus_if.dl = 32'd2;
    for (int i = 0; i < 3; i++) begin
      wait_until(800 + 200 * i);
      hi0 = hi_cnt;
      bus_if.trigger = 1'b1;
      wait_until(850 + 200 * i);
      bus_if.trigger = 1'b0;
      wait_until(950 + 200 * i);
      check("t2_rise", rise_t, 835 + 200 * i);
      check("t2_fall", fall_t, 855 + 200 * i);
      check("t2_width", hi_cnt - hi0, 2);
    end

    // dl=0 wb=3, edge at 1405
    wait_until(1400);
    bus_if.dl = 32'd0;
    bus_if.wb = 32'd3;
    hi0 = hi_cnt;
    bus_if.trigger = 1'b1;
    wait_until(1450);
    bus_if.trigger = 1'b0;
    wait_until(1500);
    check("t3_rise", rise_t, 1415);
    check("t3_fall", fall_t, 1445);
    check("t3_width", hi_cnt - hi0, 3);

    // dl=0 wb=0: no pulse, back in IDLE so the edge at 1825 is taken
    wait_until(1800);
    bus_if.wb = 32'd0;
    hi0 = hi_cnt;
    bus_if.trigger = 1'b1;
    wait_until(1810);
    bus_if.trigger = 1'b0;
    bus_if.wb = 32'd1;
    wait_until(1820);
    check("t3_zero_width", hi_cnt - hi0, 0);
    check("t3_zero_out", bus_if.delay_out, 0);
    hi0 = hi_cnt;
    bus_if.trigger = 1'b1;
    wait_until(1830);
    bus_if.trigger = 1'b0;
    wait_until(1900);
    check("t3_after_rise", rise_t, 1835);
    check("t3_after_fall", fall_t, 1845);
    check("t3_after_width", hi_cnt - hi0, 1);

    // 2/2 latched at 2105, reprogram to 9/9, second edge at 2125 in DELAY
    wait_until(2000);
    bus_if.dl = 32'd2;
    bus_if.wb = 32'd2;
    wait_until(2100);
    hi0 = hi_cnt;
    bus_if.trigger = 1'b1;
    wait_until(2110);
    bus_if.dl = 32'd9;
    bus_if.wb = 32'd9;
    bus_if.trigger = 1'b0;
    wait_until(2120);
    bus_if.trigger = 1'b1;
    wait_until(2130);
    bus_if.trigger = 1'b0;
    wait_until(2400);
`ifdef PDL_RETRIGGER_EN
    check("t4_rise", rise_t, 2225);
    check("t4_fall", fall_t, 2315);
    check("t4_width", hi_cnt - hi0, 9);
`else
    check("t4_rise", rise_t, 2135);
    check("t4_fall", fall_t, 2155);
    check("t4_width", hi_cnt - hi0, 2);
`endif

    // reset mid-pulse, trigger held high through release
    wait_until(2600);
    bus_if.dl = 32'd0;
    bus_if.wb = 32'd9;
    bus_if.trigger = 1'b1;
    wait_until(2650);
    check("t5_pulse_on", bus_if.delay_out, 1);
    reset = 1'b1;
    #1;
    check("t5_async_drop", bus_if.delay_out, 0);
    wait_until(2672);
    reset = 1'b0;
    hi0 = hi_cnt;
    wait_until(2800);
    check("t5_held_no_pulse", hi_cnt - hi0, 0);
    bus_if.trigger = 1'b0;
    wait_until(2820);
    hi0 = hi_cnt;
    bus_if.trigger = 1'b1;
    wait_until(2950);
    bus_if.trigger = 1'b0;
    check("t5_rise", rise_t, 2835);
    check("t5_fall", fall_t, 2925);
    check("t5_width", hi_cnt - hi0, 9);

    // dl=0 wb=2: edges at 3005, 3025 (final PULSE cycle), 3045 (IDLE)
    wait_until(3000);
    bus_if.dl = 32'd0;
    bus_if.wb = 32'd2;
    hi0 = hi_cnt;
    bus_if.trigger = 1'b1;
    wait_until(3010);
    bus_if.trigger = 1'b0;
    wait_until(3020);
    bus_if.trigger = 1'b1;
    wait_until(3030);
    bus_if.trigger = 1'b0;
    wait_until(3040);
`ifdef PDL_RETRIGGER_EN
    check("t6_mid", bus_if.delay_out, 1);
`else
    check("t6_mid", bus_if.delay_out, 0);
`endif
    bus_if.trigger = 1'b1;
    wait_until(3050);
    bus_if.trigger = 1'b0;
    wait_until(3060);
    check("t6_third_on", bus_if.delay_out, 1);
    wait_until(3080);
    check("t6_third_off", bus_if.delay_out, 0);
    check("t6_fall", fall_t, 3075);
`ifdef PDL_RETRIGGER_EN
    check("t6_width", hi_cnt - hi0, 6);
`else
    check("t6_width", hi_cnt - hi0, 4);
`endif

    wait_until(3150);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
